if_id_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline latch of the 5-stage MIPS.
- Holds the PC, a word-addressed instruction memory (written by the debug loader) and next-PC selection.
- Feeds ID_EX with PC+4, the fetched instruction and the halt flag.
- Consumes from ID_EX: jump/jump-register targets and flags, and the load-use stall flag.
- Consumes from EX_MEM: the branch-taken redirect.

---
 rtl/if_id_stage_pkg.sv | 26 ++
 rtl/if_id_stage_instr_mem.sv | 35 +++
 rtl/if_id_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
//   Shared constants and types for the instruction-fetch stage and its
//   IF/ID pipeline latch.
//   LEN_DATA  : datapath / instruction / PC width
//   HALT_WORD : instruction encoding that stops fetch
//   NOP_WORD  : encoding loaded into IF/ID as a bubble
//   pc_sel_e  : resolved next-state source for PC and IF/ID
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

    localparam int                LEN_DATA  = 32;
    localparam logic [LEN_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [LEN_DATA-1:0] NOP_WORD  = 32'h0000_0000;

    // Listed in priority order, highest first.
    typedef enum logic [2:0] {
        SEL_BRANCH,   // EX/MEM redirect, bubbles IF/ID, clears halt
        SEL_HOLD,     // load-use stall, PC and IF/ID keep their value
        SEL_JR,       // register jump, bubbles IF/ID
        SEL_J,        // immediate jump, bubbles IF/ID
        SEL_HALTED,   // halted: PC frozen, bubbles with halt flag kept
        SEL_SEQ       // sequential fetch
    } pc_sel_e;

endpackage

// File: rtl/if_id_stage_instr_mem.sv
// ---------------------------------------------------------------------------
// if_id_stage_instr_mem
//   Word-addressed instruction memory. Asynchronous read, synchronous write
//   from the debug loader. Contents are never reset.
//   i_clk      : clock, rising edge
//   i_wr_en    : write strobe (already qualified by the caller)
//   i_wr_addr  : write word index
//   i_wr_data  : write data
//   i_rd_addr  : read word index
//   o_rd_data  : read data, combinational
// ---------------------------------------------------------------------------
module if_id_stage_instr_mem #(
    parameter int len_data  = 32,
    parameter int mem_depth = 256,
    parameter int addr_bits = $clog2(mem_depth)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [addr_bits-1:0] i_wr_addr,
    input  logic [len_data-1:0]  i_wr_data,
    input  logic [addr_bits-1:0] i_rd_addr,
    output logic [len_data-1:0]  o_rd_data
);

    logic [len_data-1:0] r_mem [mem_depth];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   Instruction fetch plus IF/ID latch of the 5-stage MIPS pipeline.
//   Ports:
//     clk, reset (async, active low)
//     ctrl_clk_mips        : pipeline advance enable; 0 freezes all state
//                            except loader writes
//     mem_wr_en/addr/data  : debug loader port (only while frozen)
//     stall_flag           : load-use hazard, hold PC and IF/ID
//     flag_jump, in_pc_jump                   : J/JAL from ID
//     flag_jump_register, in_pc_jump_register : JR/JALR from ID
//     branch_taken, in_pc_branch_target       : branch redirect from EX/MEM
//     out_pc               : current PC
//     out_pc_branch        : IF/ID latched PC+4
//     out_instruccion      : IF/ID latched instruction
//     out_halt_flag_i      : IF/ID latched halt indicator
//     flush_id             : IF/ID takes a bubble this cycle (combinational)
// ---------------------------------------------------------------------------
import if_id_stage_pkg::*;

module if_id_stage #(
    parameter int                   len_data  = LEN_DATA,
    parameter int                   mem_depth = 256,
    parameter int                   addr_bits = $clog2(mem_depth),
    parameter logic [len_data-1:0]  halt_word = HALT_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_clk_mips,
    input  logic                 mem_wr_en,
    input  logic [addr_bits-1:0] mem_wr_addr,
    input  logic [len_data-1:0]  mem_wr_data,
    input  logic                 stall_flag,
    input  logic                 flag_jump,
    input  logic [len_data-1:0]  in_pc_jump,
    input  logic                 flag_jump_register,
    input  logic [len_data-1:0]  in_pc_jump_register,
    input  logic                 branch_taken,
    input  logic [len_data-1:0]  in_pc_branch_target,
    output logic [len_data-1:0]  out_pc,
    output logic [len_data-1:0]  out_pc_branch,
    output logic [len_data-1:0]  out_instruccion,
    output logic                 out_halt_flag_i,
    output logic                 flush_id
);

    localparam logic [len_data-1:0] BUBBLE = len_data'(NOP_WORD);

    logic [len_data-1:0] r_pc;
    logic [len_data-1:0] r_pc_branch;
    logic [len_data-1:0] r_instr;
    logic                r_halt_i;
    logic                r_halted;

    logic [len_data-1:0] w_instr;
    logic [len_data-1:0] w_pc_seq;
    logic                w_is_halt;
    logic                w_mem_wr;
    pc_sel_e             w_sel;

    // Only the word index bits address the memory; the rest of the PC is
    // carried for the datapath but never used to select an instruction.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{r_pc[len_data-1:addr_bits+2], r_pc[1:0]};

    // Loader may only write while the pipeline is frozen so it never races
    // the fetch path.
    assign w_mem_wr = mem_wr_en & ~ctrl_clk_mips;

    if_id_stage_instr_mem #(
        .len_data  (len_data),
        .mem_depth (mem_depth),
        .addr_bits (addr_bits)
    ) u_instr_mem (
        .i_clk     (clk),
        .i_wr_en   (w_mem_wr),
        .i_wr_addr (mem_wr_addr),
        .i_wr_data (mem_wr_data),
        .i_rd_addr (r_pc[addr_bits+1:2]),
        .o_rd_data (w_instr)
    );

    assign w_pc_seq  = r_pc + len_data'(4);
    assign w_is_halt = (w_instr == halt_word);

    // Branch outranks stall: the stalled instruction is on the wrong path
    // and is discarded anyway.
    always_comb begin
        w_sel = SEL_SEQ;
        if (branch_taken)            w_sel = SEL_BRANCH;
        else if (stall_flag)         w_sel = SEL_HOLD;
        else if (flag_jump_register) w_sel = SEL_JR;
        else if (flag_jump)          w_sel = SEL_J;
        else if (r_halted)           w_sel = SEL_HALTED;
    end

    assign flush_id = ctrl_clk_mips &
                      (branch_taken | (~stall_flag & (flag_jump | flag_jump_register)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_pc_branch <= '0;
            r_instr     <= BUBBLE;
            r_halt_i    <= 1'b0;
            r_halted    <= 1'b0;
        end else if (ctrl_clk_mips) begin
            unique case (w_sel)
                SEL_BRANCH: begin
                    r_pc        <= in_pc_branch_target;
                    r_pc_branch <= '0;
                    r_instr     <= BUBBLE;
                    r_halt_i    <= 1'b0;
                    r_halted    <= 1'b0;
                end
                SEL_HOLD: begin
                    r_pc        <= r_pc;
                end
                SEL_JR: begin
                    r_pc        <= in_pc_jump_register;
                    r_pc_branch <= '0;
                    r_instr     <= BUBBLE;
                    r_halt_i    <= 1'b0;
                end
                SEL_J: begin
                    r_pc        <= in_pc_jump;
                    r_pc_branch <= '0;
                    r_instr     <= BUBBLE;
                    r_halt_i    <= 1'b0;
                end
                SEL_HALTED: begin
                    // Keep signalling halt downstream while feeding bubbles.
                    r_pc_branch <= '0;
                    r_instr     <= BUBBLE;
                    r_halt_i    <= 1'b1;
                end
                default: begin
                    r_pc        <= w_pc_seq;
                    r_pc_branch <= w_pc_seq;
                    r_instr     <= w_instr;
                    r_halt_i    <= w_is_halt;
                    r_halted    <= w_is_halt;
                end
            endcase
        end
    end

    assign out_pc          = r_pc;
    assign out_pc_branch   = r_pc_branch;
    assign out_instruccion = r_instr;
    assign out_halt_flag_i = r_halt_i;

endmodule
